param_n_1_mux_reg: RTL and testbench

- Parametrised, registered N:1 multiplexer. It is the next generation of the team's combinational 4-bit 2:1 mux.
- Selects one of CHANNELS input streams of WIDTH bits each and drives it through a one-deep output register.
- Inputs and output use valid/ready handshakes.
- Two selection modes: direct select (mode=0) and round-robin arbitration (mode=1).

---
 rtl/param_n_1_mux_reg_if.sv | 27 ++
 rtl/param_n_1_mux_reg.sv | 88 ++++++++
 tb/tb_param_n_1_mux_reg.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/param_n_1_mux_reg_if.sv
// Handshake bundle for the registered N:1 multiplexer: per-channel input
// streams on one side, the single registered output stream on the other.
interface param_n_1_mux_reg_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/param_n_1_mux_reg.sv
// Registered N:1 stream multiplexer with direct-select and round-robin modes.
// One-deep output register; only the granted channel ever sees in_ready.
module param_n_1_mux_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input logic                clk,
    input logic                reset,
    param_n_1_mux_reg_if.slave bus
);
    logic [SEL_W-1:0] ptr;
    logic [WIDTH-1:0] data_p0;
    logic [SEL_W-1:0] chan_p0;
    logic             vld_p0;

    logic             load;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] ptr_next;

    assign load = !vld_p0 || bus.out_ready;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!bus.mode) begin
            // sel values at or above CHANNELS match no channel and never grant
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = int'(ptr) + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!grant_vld && bus.in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    assign ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.in_ready[i] = load && !reset && grant_vld && (grant_idx == SEL_W'(i));
        end
    end

    // stage p0: output register, refilled whenever it is empty or draining
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            chan_p0 <= '0;
            ptr     <= '0;
        end else if (load) begin
            if (grant_vld) begin
                data_p0 <= grant_data;
                chan_p0 <= grant_idx;
                vld_p0  <= 1'b1;
                if (bus.mode) ptr <= ptr_next;
            end else begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_p0;
    assign bus.out_chan  = chan_p0;
    assign bus.out_valid = vld_p0;
endmodule

// File: tb/tb_param_n_1_mux_reg.sv
// Directed bench for param_n_1_mux_reg: a 4-channel instance driven from a
// vector table, plus a 3-channel instance for illegal sel and mid-beat reset.
module tb_param_n_1_mux_reg;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    param_n_1_mux_reg_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) ifa ();
    param_n_1_mux_reg_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) ifb ();

    param_n_1_mux_reg #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    param_n_1_mux_reg #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic [15:0] data;
        logic        ordy;
        logic [3:0]  exp_ir;
        logic        exp_ov;
        logic [3:0]  exp_od;
        logic [1:0]  exp_oc;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_b_out(input string name, input logic ov, input logic [3:0] od,
                               input logic [1:0] oc);
        check({name, "_ov"}, 32'(ifb.out_valid), 32'(ov));
        check({name, "_od"}, 32'(ifb.out_data), 32'(od));
        check({name, "_oc"}, 32'(ifb.out_chan), 32'(oc));
    endtask

    initial begin
        //            mode sel iv       data      ordy ir       ov    od    oc
        vecs[0]  = '{1'b0, 2'd2, 4'b0100, 16'h0A00, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2};
        vecs[1]  = '{1'b0, 2'd2, 4'b0000, 16'h0A00, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd2};
        vecs[2]  = '{1'b0, 2'd1, 4'b0010, 16'h0050, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1};
        vecs[3]  = '{1'b0, 2'd1, 4'b0010, 16'h0060, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1};
        vecs[4]  = '{1'b0, 2'd1, 4'b0010, 16'h0060, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1};
        vecs[5]  = '{1'b0, 2'd1, 4'b0010, 16'h0060, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd1};
        vecs[6]  = '{1'b0, 2'd1, 4'b0010, 16'h0060, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
        vecs[10] = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
        vecs[11] = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        vecs[12] = '{1'b1, 2'd0, 4'b0100, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
        vecs[13] = '{1'b1, 2'd0, 4'b0101, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        vecs[14] = '{1'b1, 2'd0, 4'b0101, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
        vecs[15] = '{1'b1, 2'd0, 4'b0101, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        vecs[16] = '{1'b1, 2'd0, 4'b0000, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0};
        vecs[17] = '{1'b1, 2'd0, 4'b0101, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
        vecs[18] = '{1'b0, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        vecs[19] = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
        vecs[20] = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b0, 4'b0000, 1'b1, 4'h4, 2'd3};
        vecs[21] = '{1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.mode = 1'b0; ifa.sel = 2'd0; ifa.in_valid = 4'b1111;
        ifa.in_data = 16'h4321; ifa.out_ready = 1'b1;
        ifb.mode = 1'b0; ifb.sel = 2'd0; ifb.in_valid = 3'b111;
        ifb.in_data = 12'h321; ifb.out_ready = 1'b1;

        // Reset held two cycles with every source valid
        #1;
        check("rst_ir_c0", 32'(ifa.in_ready), 32'h0);
        tick();
        check("rst_ir_c1", 32'(ifa.in_ready), 32'h0);
        tick();
        check("rst_ov", 32'(ifa.out_valid), 32'h0);
        check("rst_od", 32'(ifa.out_data), 32'h0);
        check("rst_oc", 32'(ifa.out_chan), 32'h0);
        rst_a = 1'b0;

        for (int v = 0; v < 22; v++) begin
            ifa.mode      = vecs[v].mode;
            ifa.sel       = vecs[v].sel;
            ifa.in_valid  = vecs[v].iv;
            ifa.in_data   = vecs[v].data;
            ifa.out_ready = vecs[v].ordy;
            #1;
            check($sformatf("v%0d_ir", v), 32'(ifa.in_ready), 32'(vecs[v].exp_ir));
            tick();
            check($sformatf("v%0d_ov", v), 32'(ifa.out_valid), 32'(vecs[v].exp_ov));
            check($sformatf("v%0d_od", v), 32'(ifa.out_data), 32'(vecs[v].exp_od));
            check($sformatf("v%0d_oc", v), 32'(ifa.out_chan), 32'(vecs[v].exp_oc));
        end

        // Three-channel build: sel=3 is out of range
        rst_b = 1'b0;
        ifb.mode = 1'b0; ifb.sel = 2'd3; ifb.in_valid = 3'b111; ifb.out_ready = 1'b1;
        #1;
        check("b_badsel_ir", 32'(ifb.in_ready), 32'h0);
        tick();
        check("b_badsel_ov", 32'(ifb.out_valid), 32'h0);

        ifb.mode = 1'b1;
        #1;
        check("b_rr0_ir", 32'(ifb.in_ready), 32'b001);
        tick();
        check_b_out("b_rr0", 1'b1, 4'h1, 2'd0);

        ifb.out_ready = 1'b0;
        #1;
        check("b_hold_ir", 32'(ifb.in_ready), 32'h0);
        tick();
        check_b_out("b_hold", 1'b1, 4'h1, 2'd0);

        // Reset while a beat is stalled in the output register
        rst_b = 1'b1;
        #1;
        check("b_midrst_ir", 32'(ifb.in_ready), 32'h0);
        tick();
        check_b_out("b_midrst", 1'b0, 4'h0, 2'd0);

        rst_b = 1'b0;
        ifb.out_ready = 1'b1;
        #1;
        check("b_ptr0_ir", 32'(ifb.in_ready), 32'b001);
        tick();
        check_b_out("b_ptr0", 1'b1, 4'h1, 2'd0);

        ifb.in_valid = 3'b100;
        #1;
        check("b_last_ir", 32'(ifb.in_ready), 32'b100);
        tick();
        check_b_out("b_last", 1'b1, 4'h3, 2'd2);

        ifb.in_valid = 3'b111;
        #1;
        check("b_wrap_ir", 32'(ifb.in_ready), 32'b001);
        tick();
        check_b_out("b_wrap", 1'b1, 4'h1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
